// File: rtl/bist_sequencer_pkg.sv
// Shared definitions for the BIST session sequencer: state encoding, control
// bundle and the default signature settings.
package bist_sequencer_pkg;

   localparam int                       DEFAULT_SIG_W      = 4;
   localparam logic [DEFAULT_SIG_W-1:0] DEFAULT_GOLDEN_SIG = 4'b0011;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RUN   = 3'd2,
      ST_FLUSH = 3'd3,
      ST_CHECK = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   typedef struct packed {
      logic test_sel;
      logic lfsr_clr;
      logic misr_clr;
      logic lfsr_en;
      logic misr_en;
      logic busy;
      logic done;
   } ctrl_t;

   // Moore decode: the datapath controls that belong to each state.
   function automatic ctrl_t decode_ctrl(input state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         ST_CLEAR: begin
            c.lfsr_clr = 1'b1;
            c.misr_clr = 1'b1;
            c.test_sel = 1'b1;
            c.busy     = 1'b1;
         end
         ST_RUN: begin
            c.lfsr_en  = 1'b1;
            c.misr_en  = 1'b1;
            c.test_sel = 1'b1;
            c.busy     = 1'b1;
         end
         ST_FLUSH: begin
            c.misr_en  = 1'b1;
            c.test_sel = 1'b1;
            c.busy     = 1'b1;
         end
         ST_CHECK: begin
            c.test_sel = 1'b1;
            c.busy     = 1'b1;
         end
         ST_DONE:  c.done = 1'b1;
         default:  c = '0;
      endcase
      return c;
   endfunction

   function automatic logic in_session(input state_e s);
      return (s == ST_CLEAR) || (s == ST_RUN) || (s == ST_FLUSH) || (s == ST_CHECK);
   endfunction

endpackage

// File: rtl/bist_phase_counter.sv
// Phase counter for the BIST sequencer: synchronous clear to zero, increment,
// and a terminal flag raised when the count equals the supplied terminal value.
module bist_phase_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   input  logic [CNT_W-1:0] term,
   output logic [CNT_W-1:0] count,
   output logic             at_term
);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of the order in which blocks are evaluated.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CNT_W'(1);
      end
   end

   assign at_term = (count == term);

endmodule

// File: rtl/bist_sequencer.sv
// BIST session sequencer: clears LFSR/MISR, runs the pattern phase, flushes the
// CUT->MISR path, then checks the signature against the golden value.
module bist_sequencer
   import bist_sequencer_pkg::*;
#(
   parameter int               NUM_PATTERNS = 7,
   parameter int               FLUSH_CYCLES = 1,
   parameter int               SIG_W        = DEFAULT_SIG_W,
   parameter logic [SIG_W-1:0] GOLDEN_SIG   = DEFAULT_GOLDEN_SIG,
   parameter int               CNT_W        = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             testmode,
   input  logic [SIG_W-1:0] signature,
   output logic             test_sel,
   output logic             lfsr_clr,
   output logic             misr_clr,
   output logic             lfsr_en,
   output logic             misr_en,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             fault_detected,
   output logic             aborted
);

   localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(NUM_PATTERNS - 1);
   localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
   localparam state_e           AFTER_RUN  = (FLUSH_CYCLES > 0) ? ST_FLUSH : ST_CHECK;

   state_e           state;
   ctrl_t            ctrl;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] term;
   logic             at_term;
   logic             cnt_inc;

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      term    = RUN_LAST;
      cnt_inc = 1'b0;
      if (state == ST_FLUSH) begin
         term = FLUSH_LAST;
      end
      if (testmode && ((state == ST_RUN) || (state == ST_FLUSH)) && !at_term) begin
         cnt_inc = 1'b1;
      end
   end

   // Any cycle that is not a mid-phase advance returns the counter to zero,
   // so each phase starts from 0 and an abort leaves no stale count behind.
   bist_phase_counter #(
      .CNT_W (CNT_W)
   ) u_phase_counter (
      .clock   (clock),
      .reset   (reset),
      .clr     (!cnt_inc),
      .inc     (cnt_inc),
      .term    (term),
      .count   (count),
      .at_term (at_term)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         ctrl           <= '0;
         pass           <= 1'b0;
         fault_detected <= 1'b0;
         aborted        <= 1'b0;
      end else begin
         aborted <= 1'b0;
         if (in_session(state) && !testmode) begin
            state   <= ST_IDLE;
            ctrl    <= decode_ctrl(ST_IDLE);
            aborted <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start && testmode) begin
                     state          <= ST_CLEAR;
                     ctrl           <= decode_ctrl(ST_CLEAR);
                     pass           <= 1'b0;
                     fault_detected <= 1'b0;
                  end
               end
               ST_CLEAR: begin
                  state <= ST_RUN;
                  ctrl  <= decode_ctrl(ST_RUN);
               end
               ST_RUN: begin
                  if (at_term) begin
                     state <= AFTER_RUN;
                     ctrl  <= decode_ctrl(AFTER_RUN);
                  end
               end
               ST_FLUSH: begin
                  if (at_term) begin
                     state <= ST_CHECK;
                     ctrl  <= decode_ctrl(ST_CHECK);
                  end
               end
               ST_CHECK: begin
                  state          <= ST_DONE;
                  ctrl           <= decode_ctrl(ST_DONE);
                  pass           <= (signature == GOLDEN_SIG);
                  fault_detected <= (signature != GOLDEN_SIG);
               end
               ST_DONE: begin
                  // Requires start to drop first: no automatic restart.
                  if (!start) begin
                     state <= ST_IDLE;
                     ctrl  <= decode_ctrl(ST_IDLE);
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  ctrl  <= decode_ctrl(ST_IDLE);
               end
            endcase
         end
      end
   end

   assign test_sel = ctrl.test_sel;
   assign lfsr_clr = ctrl.lfsr_clr;
   assign misr_clr = ctrl.misr_clr;
   assign lfsr_en  = ctrl.lfsr_en;
   assign misr_en  = ctrl.misr_en;
   assign busy     = ctrl.busy;
   assign done     = ctrl.done;

endmodule

// File: tb/tb_bist_sequencer.sv
// Self-checking bench for bist_sequencer: a session-position model checked every
// cycle on two configurations, plus directed literal expectations.
module tb_bist_sequencer;

   localparam logic [3:0] GOLD = 4'b0011;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       testmode;
   logic [3:0] signature;

   logic d1_test_sel, d1_lfsr_clr, d1_misr_clr, d1_lfsr_en, d1_misr_en;
   logic d1_busy, d1_done, d1_pass, d1_fault, d1_aborted;
   logic d2_test_sel, d2_lfsr_clr, d2_misr_clr, d2_lfsr_en, d2_misr_en;
   logic d2_busy, d2_done, d2_pass, d2_fault, d2_aborted;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bist_sequencer dut1 (
      .clock (clk), .reset (reset), .start (start), .testmode (testmode),
      .signature (signature), .test_sel (d1_test_sel), .lfsr_clr (d1_lfsr_clr),
      .misr_clr (d1_misr_clr), .lfsr_en (d1_lfsr_en), .misr_en (d1_misr_en),
      .busy (d1_busy), .done (d1_done), .pass (d1_pass),
      .fault_detected (d1_fault), .aborted (d1_aborted)
   );

   bist_sequencer #(.NUM_PATTERNS (1), .FLUSH_CYCLES (0)) dut2 (
      .clock (clk), .reset (reset), .start (start), .testmode (testmode),
      .signature (signature), .test_sel (d2_test_sel), .lfsr_clr (d2_lfsr_clr),
      .misr_clr (d2_misr_clr), .lfsr_en (d2_lfsr_en), .misr_en (d2_misr_en),
      .busy (d2_busy), .done (d2_done), .pass (d2_pass),
      .fault_detected (d2_fault), .aborted (d2_aborted)
   );

   logic [9:0] act1, act2;
   assign act1 = {d1_test_sel, d1_lfsr_clr, d1_misr_clr, d1_lfsr_en, d1_misr_en,
                  d1_busy, d1_done, d1_pass, d1_fault, d1_aborted};
   assign act2 = {d2_test_sel, d2_lfsr_clr, d2_misr_clr, d2_lfsr_en, d2_misr_en,
                  d2_busy, d2_done, d2_pass, d2_fault, d2_aborted};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: pos is the cycle number within a session (0 = idle, 1 = clear,
   // then np pattern cycles, fc flush cycles, one check cycle, then done).
   typedef struct {
      int   pos;
      logic pass;
      logic fault;
      logic ab;
   } model_t;

   function automatic model_t step(input model_t m, input int np, input int fc,
                                   input logic st, input logic tm, input logic [3:0] sig);
      model_t n;
      int     last;
      n    = m;
      last = np + fc + 2;
      n.ab = 1'b0;
      if (m.pos == 0) begin
         if (st && tm) begin
            n.pos   = 1;
            n.pass  = 1'b0;
            n.fault = 1'b0;
         end
      end else if (m.pos <= last) begin
         if (!tm) begin
            n.pos = 0;
            n.ab  = 1'b1;
         end else begin
            n.pos = m.pos + 1;
            if (m.pos == last) begin
               n.pass  = (sig == GOLD);
               n.fault = (sig != GOLD);
            end
         end
      end else if (!st) begin
         n.pos = 0;
      end
      return n;
   endfunction

   function automatic logic [9:0] expect_out(input model_t m, input int np, input int fc);
      logic clr_c, len_c, men_c, act_c, dn_c;
      clr_c = (m.pos == 1);
      len_c = (m.pos >= 2) && (m.pos <= np + 1);
      men_c = (m.pos >= 2) && (m.pos <= np + fc + 1);
      act_c = (m.pos >= 1) && (m.pos <= np + fc + 2);
      dn_c  = (m.pos == np + fc + 3);
      return {act_c, clr_c, clr_c, len_c, men_c, act_c, dn_c, m.pass, m.fault, m.ab};
   endfunction

   model_t m1 = '{pos: 0, pass: 1'b0, fault: 1'b0, ab: 1'b0};
   model_t m2 = '{pos: 0, pass: 1'b0, fault: 1'b0, ab: 1'b0};

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m1 <= '{pos: 0, pass: 1'b0, fault: 1'b0, ab: 1'b0};
         m2 <= '{pos: 0, pass: 1'b0, fault: 1'b0, ab: 1'b0};
      end else begin
         m1 <= step(m1, 7, 1, start, testmode, signature);
         m2 <= step(m2, 1, 0, start, testmode, signature);
      end
   end

   always @(negedge clk) begin
      check("dut1_outputs", 32'(act1), 32'(expect_out(m1, 7, 1)));
      check("dut2_outputs", 32'(act2), 32'(expect_out(m2, 1, 0)));
   end

   int   n_lclr1, n_mclr1, n_len1, n_men1, n_men2, n_done1, done_cyc1, done_cyc2;
   logic pass_at_clear, fault_at_clear;

   // Raises start on a falling edge and observes until dut1 has shown done
   // for hold further cycles; start is left high for the caller to drop.
   task automatic run_session(input int hold);
      n_lclr1 = 0; n_mclr1 = 0; n_len1 = 0; n_men1 = 0; n_men2 = 0;
      n_done1 = 0; done_cyc1 = 0; done_cyc2 = 0;
      start = 1'b1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            pass_at_clear  = d1_pass;
            fault_at_clear = d1_fault;
         end
         n_lclr1 += int'(d1_lfsr_clr);
         n_mclr1 += int'(d1_misr_clr);
         n_len1  += int'(d1_lfsr_en);
         n_men1  += int'(d1_misr_en);
         n_men2  += int'(d2_misr_en);
         n_done1 += int'(d1_done);
         if (d1_done && done_cyc1 == 0) done_cyc1 = cyc;
         if (d2_done && done_cyc2 == 0) done_cyc2 = cyc;
         if (done_cyc1 != 0 && cyc >= done_cyc1 + hold) break;
      end
   endtask

   int n_abort_done;

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      testmode  = 1'b0;
      signature = 4'b0000;
      #3;
      check("reset_out_dut1", 32'(act1), 32'd0);
      check("reset_out_dut2", 32'(act2), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset     = 1'b0;
      testmode  = 1'b1;
      signature = GOLD;
      repeat (2) @(negedge clk);

      // Passing session, start held 5 cycles into DONE.
      run_session(5);
      check("lfsr_clr_cycles", n_lclr1, 1);
      check("misr_clr_cycles", n_mclr1, 1);
      check("lfsr_en_cycles", n_len1, 7);
      check("misr_en_cycles", n_men1, 8);
      check("done_latency", done_cyc1, 11);
      check("done_held_cycles", n_done1, 6);
      check("pass_good_sig", d1_pass, 1);
      check("fault_good_sig", d1_fault, 0);
      check("short_misr_en_cycles", n_men2, 1);
      check("short_done_latency", done_cyc2, 4);
      start = 1'b0;
      @(negedge clk);
      check("done_drops", d1_done, 0);
      check("pass_held_idle", d1_pass, 1);

      // Failing signature; pass from the previous session cleared in CLEAR.
      signature = 4'b0101;
      run_session(0);
      check("pass_cleared_in_clear", pass_at_clear, 0);
      check("fail_done_latency", done_cyc1, 11);
      check("pass_bad_sig", d1_pass, 0);
      check("fault_bad_sig", d1_fault, 1);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("fault_sticky", d1_fault, 1);
      check("done_low_after", d1_done, 0);

      // Abort: testmode drops at RUN count 3.
      signature = GOLD;
      start     = 1'b1;
      @(negedge clk);
      check("fault_cleared_in_clear", d1_fault, 0);
      repeat (4) @(negedge clk);
      check("run_before_abort", d1_lfsr_en, 1);
      testmode = 1'b0;
      @(negedge clk);
      check("abort_pulse", d1_aborted, 1);
      check("abort_enables", {d1_lfsr_en, d1_misr_en, d1_test_sel}, 0);
      @(negedge clk);
      check("abort_pulse_ends", d1_aborted, 0);
      n_abort_done = 0;
      repeat (15) begin
         @(negedge clk);
         n_abort_done += int'(d1_done);
      end
      check("no_done_after_abort", n_abort_done, 0);
      start    = 1'b0;
      testmode = 1'b1;
      repeat (2) @(negedge clk);

      // Asynchronous reset in the middle of FLUSH.
      start = 1'b1;
      repeat (9) @(negedge clk);
      check("in_flush", {d1_lfsr_en, d1_misr_en}, 2'b01);
      start = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("async_reset_out", 32'(act1), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_after_reset", {d1_busy, d1_done, d1_lfsr_clr}, 0);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
